// File: rtl/mem_buf_ctrl_if.sv
// mem_buf_ctrl_if: producer, consumer, buffer and status signals of mem_buf_ctrl
interface mem_buf_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic req0, req1, gnt0, gnt1;
    logic [DATA_W-1:0] data0, data1;
    logic rd_req, rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic mem_w, mem_r;
    logic [ADDR_W-1:0] mem_w_addr, mem_r_addr;
    logic [DATA_W-1:0] mem_data_in, mem_data_out;
    logic full, empty;
    logic [ADDR_W:0] count;
    modport master (
        output req0, req1, data0, data1, rd_req, mem_data_out,
        input gnt0, gnt1, rd_valid, rd_data, mem_w, mem_r, mem_w_addr, mem_r_addr,
        input mem_data_in, full, empty, count
    );
    modport slave (
        input req0, req1, data0, data1, rd_req, mem_data_out,
        output gnt0, gnt1, rd_valid, rd_data, mem_w, mem_r, mem_w_addr, mem_r_addr,
        output mem_data_in, full, empty, count
    );
endinterface

// File: rtl/mem_buf_ctrl.sv
// mem_buf_ctrl: two-producer round-robin write arbiter and one-consumer read
// controller around an external buffer with one-cycle registered read.
module mem_buf_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input logic clk,
    input logic rst,
    mem_buf_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0] cnt;
    logic prio, rv, full, empty, gnt0, gnt1, wr, rd;
    assign full  = cnt == DEPTH;
    assign empty = cnt == '0;
    // prio = 0 favours producer 0 on contention
    assign gnt0 = !rst && !full && bus.req0 && (!bus.req1 || !prio);
    assign gnt1 = !rst && !full && bus.req1 && (!bus.req0 || prio);
    assign wr   = gnt0 | gnt1;
    assign rd   = !rst && bus.rd_req && !empty;
    assign bus.gnt0        = gnt0;
    assign bus.gnt1        = gnt1;
    assign bus.mem_w       = wr;
    assign bus.mem_w_addr  = wr_ptr;
    assign bus.mem_data_in = gnt1 ? bus.data1 : bus.data0;
    assign bus.mem_r       = rd;
    assign bus.mem_r_addr  = rd_ptr;
    // a read issued just before reset must not surface while reset is held
    assign bus.rd_valid    = rv && !rst;
    assign bus.rd_data     = bus.mem_data_out;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.count       = cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            prio   <= 1'b0;
            rv     <= 1'b0;
        end else begin
            wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
            cnt    <= cnt + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
            prio   <= wr ? gnt0 : prio;
            rv     <= rd;
        end
    end
endmodule

// File: tb/tb_mem_buf_ctrl.sv
// tb_mem_buf_ctrl: directed checks of arbitration, fill/drain, read latency,
// full/empty boundaries and mid-operation reset.
module tb_mem_buf_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    logic clk, rst;
    int n_chk, n_fail, n0, n1;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    mem_buf_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b ();
    mem_buf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(b));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (b.mem_w) mem[b.mem_w_addr] <= b.mem_data_in;
        if (b.mem_r) b.mem_data_out <= mem[b.mem_r_addr];
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1; b.req0 = 0; b.req1 = 0; b.rd_req = 0;
        tick;
        rst = 0;
    endtask
    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1; b.req0 = 1; b.req1 = 1; b.rd_req = 1; b.data0 = '0; b.data1 = '0;
        tick; tick;
        chk("rst_gnt0", b.gnt0, 0); chk("rst_gnt1", b.gnt1, 0);
        chk("rst_mem_w", b.mem_w, 0); chk("rst_mem_r", b.mem_r, 0);
        chk("rst_empty", b.empty, 1); chk("rst_full", b.full, 0);
        chk("rst_count", b.count, 0); chk("rst_rd_valid", b.rd_valid, 0);
        rst = 0; b.req0 = 0; b.req1 = 0; b.rd_req = 1;
        #1;
        chk("er_mem_r", b.mem_r, 0); chk("er_empty", b.empty, 1); chk("er_gnt0", b.gnt0, 0);
        tick;
        chk("er_rd_valid", b.rd_valid, 0); chk("er_count", b.count, 0);
        b.rd_req = 0;
        for (int i = 0; i < 16; i++) begin
            b.req0 = 1; b.data0 = 16'(i + 1);
            #1;
            chk("fill_gnt0", b.gnt0, 1); chk("fill_waddr", b.mem_w_addr, i);
            chk("fill_wdata", b.mem_data_in, i + 1);
            tick;
        end
        #1;
        chk("fill_count", b.count, 16); chk("fill_full", b.full, 1);
        chk("fill_gnt0_17", b.gnt0, 0); chk("fill_mem_w_17", b.mem_w, 0);
        b.req0 = 0;
        for (int i = 0; i < 16; i++) begin
            b.rd_req = 1;
            #1;
            chk("drain_mem_r", b.mem_r, 1); chk("drain_raddr", b.mem_r_addr, i);
            tick;
            chk("drain_valid", b.rd_valid, 1); chk("drain_data", b.rd_data, i + 1);
        end
        b.rd_req = 0;
        #1;
        chk("drain_empty", b.empty, 1); chk("drain_mem_r_off", b.mem_r, 0);
        tick;
        chk("drain_valid_off", b.rd_valid, 0);
        do_reset;
        n0 = 0; n1 = 0;
        b.req0 = 1; b.req1 = 1;
        for (int i = 0; i < 16; i++) begin
            b.data0 = 16'(32'h100 + i); b.data1 = 16'(32'h200 + i);
            #1;
            chk("rr_gnt0", b.gnt0, (i % 2 == 0)); chk("rr_gnt1", b.gnt1, (i % 2 == 1));
            n0 += int'(b.gnt0); n1 += int'(b.gnt1);
            tick;
        end
        #1;
        chk("rr_n0", n0, 8); chk("rr_n1", n1, 8); chk("rr_full", b.full, 1);
        chk("rr_nogrant", b.gnt0 | b.gnt1, 0);
        b.req0 = 0; b.req1 = 1; b.rd_req = 1;
        #1;
        chk("sim_full_gnt1", b.gnt1, 0); chk("sim_full_mem_r", b.mem_r, 1);
        chk("sim_full_raddr", b.mem_r_addr, 0);
        tick;
        chk("sim_count1", b.count, 15); chk("sim_valid1", b.rd_valid, 1);
        chk("sim_data1", b.rd_data, 16'h100);
        chk("sim_gnt1", b.gnt1, 1); chk("sim_waddr_wrap", b.mem_w_addr, 0);
        chk("sim_raddr", b.mem_r_addr, 1); chk("sim_wdata", b.mem_data_in, 16'h20F);
        tick;
        chk("sim_count2", b.count, 15); chk("sim_data2", b.rd_data, 16'h201);
        chk("sim_notfull", b.full, 0);
        b.req1 = 0; b.rd_req = 0;
        do_reset;
        b.req0 = 1; b.data0 = 16'hA5A5;
        #1;
        chk("lat_waddr", b.mem_w_addr, 0);
        tick;
        b.req0 = 0; b.rd_req = 1;
        #1;
        chk("lat_mem_r", b.mem_r, 1); chk("lat_raddr", b.mem_r_addr, 0);
        chk("lat_valid_early", b.rd_valid, 0);
        tick;
        b.rd_req = 0;
        chk("lat_valid", b.rd_valid, 1); chk("lat_data", b.rd_data, 16'hA5A5);
        chk("lat_empty", b.empty, 1);
        tick;
        chk("lat_valid_off", b.rd_valid, 0);
        do_reset;
        for (int i = 0; i < 5; i++) begin
            b.req0 = 1; b.data0 = 16'(32'h50 + i);
            tick;
        end
        b.req0 = 0;
        chk("mr_count5", b.count, 5);
        b.rd_req = 1;
        #1;
        chk("mr_mem_r", b.mem_r, 1);
        tick;
        rst = 1; b.rd_req = 0;
        #1;
        chk("mr_valid_in_rst", b.rd_valid, 0);
        tick;
        rst = 0;
        chk("mr_count", b.count, 0); chk("mr_empty", b.empty, 1);
        chk("mr_valid", b.rd_valid, 0);
        b.req0 = 1; b.data0 = 16'h77;
        #1;
        chk("mr_gnt0", b.gnt0, 1); chk("mr_waddr", b.mem_w_addr, 0);
        tick;
        b.req0 = 0;
        chk("mr_count1", b.count, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_buf_ctrl.md
MEM_BUF_CTRL -- requirements
Module: mem_buf_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, giving the buffer address width and a depth of 2^ADDR_W words.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the data word width.
REQ-003 The block SHALL have the following ports, one per line (name, direction, width, meaning); clk and rst are listed first.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  write request from producer 0 / producer 1.
- data0 / data1  in  DATA_W  write data from producer 0 / producer 1.
- gnt0 / gnt1  out  1  combinational write grant; the write completes at the next edge.
- rd_req  in  1  consumer read request.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  DATA_W  read word.
- mem_w, mem_r  out  1  write and read strobes to the buffer.
- mem_w_addr, mem_r_addr  out  ADDR_W  buffer write and read addresses.
- mem_data_in  out  DATA_W  buffer write data.
- mem_data_out  in  DATA_W  buffer read data, registered, available one cycle after mem_r.
- full, empty  out  1  occupancy flags.
- count  out  ADDR_W+1  number of stored words.

Function
REQ-004 The block SHALL keep a write pointer (wr_ptr), a read pointer (rd_ptr) and count, all registered.
- Each pointer is ADDR_W bits wide.
- count ranges from 0 to 2^ADDR_W.
REQ-005 The flags SHALL be decoded from count: full = (count == 2^ADDR_W) and empty = (count == 0).
REQ-006 The block SHALL accept at most one write per cycle.
- A write is accepted only when !full.
- If exactly one of req0/req1 is high, that requester is granted.
REQ-007 When req0 and req1 are both high and !full, the grant SHALL go to the requester holding round-robin priority.
- A priority register (prio) names the requester with priority.
- After any grant, prio moves to the other requester.
- prio is unchanged in cycles with no grant.
REQ-008 gnt0 and gnt1 SHALL be one-hot or zero, and both SHALL be 0 when full or when rst is high.
REQ-009 The write port SHALL be driven combinationally.
- mem_w = gnt0|gnt1.
- mem_w_addr = wr_ptr.
- mem_data_in = data of the granted requester, or data0 when there is no grant.
REQ-010 A read SHALL be accepted when rd_req && !empty.
- mem_r = 1 and mem_r_addr = rd_ptr in the same cycle.
- rd_ptr increments at the edge.
REQ-011 rd_valid SHALL be a register set one cycle after each accepted read, with rd_data = mem_data_out in that cycle (read latency 1); rd_data SHALL be don't-care when rd_valid is 0.
REQ-012 Pointers SHALL wrap modulo 2^ADDR_W: (2^ADDR_W-1)+1 -> 0.
REQ-013 count SHALL update as follows:
- +1 on a write only.
- -1 on a read only.
- unchanged when a write and a read occur in the same cycle, or when neither occurs.
REQ-014 Flags SHALL be evaluated from the registered count before the cycle's operations.
- When full with rd_req and a pending write, only the read occurs; the write is granted the next cycle.
- When empty with rd_req and a write, only the write occurs; the read is accepted the next cycle.
REQ-015 count SHALL never exceed 2^ADDR_W or go below 0.

Reset
REQ-016 When rst is high at a rising edge, the following SHALL be cleared regardless of the operation in progress:
- wr_ptr = 0, rd_ptr = 0, count = 0.
- prio = requester 0.
- rd_valid = 0.
REQ-017 During reset and in the first cycle after it, the outputs SHALL take these values:
- empty = 1, full = 0, count = 0.
- gnt0 = gnt1 = 0 and mem_w = 0 while rst is high.
- mem_r = 0.
REQ-018 A read accepted in the cycle before reset SHALL NOT produce rd_valid after reset is asserted.

Verification
REQ-019 Single-requester fill: req0=1 with data 1..16 over 16 cycles, no reads -> gnt0 high each cycle, mem_w_addr 0..15, count=16, full=1, and gnt0=0 on the 17th request.
REQ-020 Fairness: req0=req1=1 continuously from empty -> grants alternate 0,1,0,1..., and producer 0 and producer 1 each receive 8 writes before full.
REQ-021 Read latency: after writing 0xA5A5 at address 0, pulse rd_req one cycle -> mem_r=1 with mem_r_addr=0, then rd_valid=1 with rd_data=0xA5A5 exactly one cycle later, and empty=1 after that.
REQ-022 Simultaneous operations: count=16 (full) with rd_req=1 and req1=1 -> read only, count=15; next cycle write and read together -> count stays 15; the pointers wrap from 15 to 0.
REQ-023 Empty read: rd_req=1 with count=0 -> mem_r=0, rd_valid stays 0, count stays 0.
REQ-024 Reset mid-operation: count=5 with a read in flight, assert rst for one cycle -> count=0, empty=1, rd_valid=0, and the next write goes to address 0.
